// File: rtl/alu_sequencer.sv
// Request-side controller for the 8-bit ALU: sequences one or two chained ALU passes
// per request, captures F/carry after a settle time and returns them over valid/ready.
module alu_sequencer #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_mode,
    input  logic [3:0]  req_selector,
    input  logic        req_carry_in,
    input  logic        req_wide,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        alu_mode,
    output logic [3:0]  alu_selector,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_carry_in,
    input  logic [7:0]  alu_f,
    input  logic        alu_carry_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_carry,
    output logic        rsp_zero
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 7) begin : gBadSettle
            $error("alu_sequencer: SETTLE_CYCLES must be within 1..7");
        end
    endgenerate

    localparam logic [2:0] LAST_COUNT = 3'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, RESP} stateType;

    stateType    state;
    stateType    nextState;
    logic        modeReg;
    logic [3:0]  selectorReg;
    logic        carryInReg;
    logic        wideReg;
    logic [15:0] aReg;
    logic [15:0] bReg;
    logic [2:0]  settleCount;
    logic        lastSettle;
    logic [15:0] resultReg;
    logic        lowCarry;
    logic        carryReg;
    logic        zeroReg;

    assign lastSettle = (settleCount == LAST_COUNT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; the ALU inputs are only non-zero while a pass is in progress.
    always_comb begin
        nextState    = state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        alu_mode     = 1'b0;
        alu_selector = 4'd0;
        alu_a        = 8'd0;
        alu_b        = 8'd0;
        alu_carry_in = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    nextState = LOW;
                end
            end
            LOW: begin
                alu_mode     = modeReg;
                alu_selector = selectorReg;
                alu_a        = aReg[7:0];
                alu_b        = bReg[7:0];
                alu_carry_in = carryInReg;
                if (lastSettle) begin
                    nextState = wideReg ? HIGH : RESP;
                end
            end
            HIGH: begin
                alu_mode     = modeReg;
                alu_selector = selectorReg;
                alu_a        = aReg[15:8];
                alu_b        = bReg[15:8];
                alu_carry_in = lowCarry;
                if (lastSettle) begin
                    nextState = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Zero flag is registered at the final capture so it stays 0 out of reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            modeReg     <= 1'b0;
            selectorReg <= 4'd0;
            carryInReg  <= 1'b0;
            wideReg     <= 1'b0;
            aReg        <= 16'd0;
            bReg        <= 16'd0;
            settleCount <= 3'd0;
            resultReg   <= 16'd0;
            lowCarry    <= 1'b0;
            carryReg    <= 1'b0;
            zeroReg     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        modeReg     <= req_mode;
                        selectorReg <= req_selector;
                        carryInReg  <= req_carry_in;
                        wideReg     <= req_wide;
                        aReg        <= req_a;
                        bReg        <= req_b;
                        settleCount <= 3'd0;
                        resultReg   <= 16'd0;
                        lowCarry    <= 1'b0;
                        carryReg    <= 1'b0;
                        zeroReg     <= 1'b0;
                    end
                end
                LOW: begin
                    if (lastSettle) begin
                        settleCount     <= 3'd0;
                        resultReg[7:0]  <= alu_f;
                        lowCarry        <= alu_carry_out;
                        if (!wideReg) begin
                            carryReg <= alu_carry_out;
                            zeroReg  <= (alu_f == 8'd0);
                        end
                    end else begin
                        settleCount <= settleCount + 3'd1;
                    end
                end
                HIGH: begin
                    if (lastSettle) begin
                        settleCount     <= 3'd0;
                        resultReg[15:8] <= alu_f;
                        carryReg        <= alu_carry_out;
                        zeroReg         <= (alu_f == 8'd0) && (resultReg[7:0] == 8'd0);
                    end else begin
                        settleCount <= settleCount + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_result = resultReg;
    assign rsp_carry  = carryReg;
    assign rsp_zero   = zeroReg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: ALU stub plus an arithmetic reference model,
// directed corner cases and randomized operations.
module tb_alu_sequencer;

    localparam int SETTLE = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_mode;
    logic [3:0]  req_selector;
    logic        req_carry_in;
    logic        req_wide;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        alu_mode;
    logic [3:0]  alu_selector;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_carry_in;
    logic [7:0]  alu_f;
    logic        alu_carry_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic        rsp_carry;
    logic        rsp_zero;

    int assertCount = 0;
    int failCount   = 0;

    alu_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mode(req_mode), .req_selector(req_selector),
        .req_carry_in(req_carry_in), .req_wide(req_wide),
        .req_a(req_a), .req_b(req_b),
        .alu_mode(alu_mode), .alu_selector(alu_selector),
        .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in),
        .alu_f(alu_f), .alu_carry_out(alu_carry_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry), .rsp_zero(rsp_zero)
    );

    always #5 clock = ~clock;

    // ALU stub: add with carry, result scrambled by mode/selector so pass-through is visible.
    logic [8:0] aluSum;
    assign aluSum        = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_carry_in};
    assign alu_f         = aluSum[7:0] ^ {alu_selector, 3'b000, alu_mode};
    assign alu_carry_out = aluSum[8];

    typedef struct packed {
        logic [15:0] result;
        logic        carry;
        logic        zero;
        logic        midCarry;
    } refType;

    function automatic refType refOp(input logic [15:0] a, input logic [15:0] b,
                                     input logic cin, input logic wide,
                                     input logic mode, input logic [3:0] sel);
        refType r;
        int     lowSum;
        int     highSum;
        logic [7:0] mask;
        mask    = {sel, 3'b000, mode};
        lowSum  = int'(a[7:0]) + int'(b[7:0]) + int'(cin);
        r.midCarry = (lowSum >= 256);
        if (wide) begin
            highSum  = int'(a[15:8]) + int'(b[15:8]) + int'(r.midCarry);
            r.result = {8'(highSum) ^ mask, 8'(lowSum) ^ mask};
            r.carry  = (highSum >= 256);
        end else begin
            r.result = {8'd0, 8'(lowSum) ^ mask};
            r.carry  = r.midCarry;
        end
        r.zero = (r.result == 16'd0);
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAluIdle(input string tag);
        checkOutput({tag, " alu_a"}, 32'(alu_a), 32'd0);
        checkOutput({tag, " alu_b"}, 32'(alu_b), 32'd0);
        checkOutput({tag, " alu_cin"}, 32'(alu_carry_in), 32'd0);
        checkOutput({tag, " alu_mode"}, 32'(alu_mode), 32'd0);
        checkOutput({tag, " alu_sel"}, 32'(alu_selector), 32'd0);
    endtask

    // Drives one request from IDLE, checks both passes cycle by cycle and the response.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                 input logic wide, input logic mode, input logic [3:0] sel,
                                 input int holdCycles, input logic junkValid);
        refType exp;
        int     passes;
        exp    = refOp(a, b, cin, wide, mode, sel);
        passes = wide ? 2 : 1;
        @(negedge clock);
        checkOutput("ready before request", 32'(req_ready), 32'd1);
        req_a = a; req_b = b; req_carry_in = cin; req_wide = wide;
        req_mode = mode; req_selector = sel; req_valid = 1'b1;
        @(posedge clock);
        #1;
        req_valid = junkValid;
        req_a = 16'($urandom); req_b = 16'($urandom);
        req_carry_in = 1'($urandom); req_wide = 1'($urandom);
        for (int p = 0; p < passes; p++) begin
            for (int c = 0; c < SETTLE; c++) begin
                @(negedge clock);
                checkOutput("alu_a", 32'(alu_a), 32'(p == 0 ? a[7:0] : a[15:8]));
                checkOutput("alu_b", 32'(alu_b), 32'(p == 0 ? b[7:0] : b[15:8]));
                checkOutput("alu_cin", 32'(alu_carry_in), 32'(p == 0 ? cin : exp.midCarry));
                checkOutput("alu_mode", 32'(alu_mode), 32'(mode));
                checkOutput("alu_sel", 32'(alu_selector), 32'(sel));
                checkOutput("rsp_valid early", 32'(rsp_valid), 32'd0);
                checkOutput("ready busy", 32'(req_ready), 32'd0);
            end
        end
        for (int h = 0; h <= holdCycles; h++) begin
            @(negedge clock);
            checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("rsp_result", 32'(rsp_result), 32'(exp.result));
            checkOutput("rsp_carry", 32'(rsp_carry), 32'(exp.carry));
            checkOutput("rsp_zero", 32'(rsp_zero), 32'(exp.zero));
            checkOutput("ready in resp", 32'(req_ready), 32'd0);
            checkAluIdle("resp");
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(posedge clock);
        #1;
        rsp_ready = 1'b0;
        @(negedge clock);
        checkOutput("rsp_valid after handshake", 32'(rsp_valid), 32'd0);
        checkOutput("ready after handshake", 32'(req_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b1; rsp_ready = 1'b1; req_valid = 1'b1;
        req_a = 16'hA5C3; req_b = 16'h3C5A; req_carry_in = 1'b1; req_wide = 1'b1;
        req_mode = 1'b1; req_selector = 4'hF;
        repeat (3) @(negedge clock);
        checkOutput("reset req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset rsp_result", 32'(rsp_result), 32'd0);
        checkOutput("reset rsp_carry", 32'(rsp_carry), 32'd0);
        checkOutput("reset rsp_zero", 32'(rsp_zero), 32'd0);
        checkAluIdle("reset");
        req_valid = 1'b0; rsp_ready = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        checkOutput("ready after reset", 32'(req_ready), 32'd1);

        applyStimulus(16'h0012, 16'h0034, 1'b0, 1'b0, 1'b0, 4'h0, 0, 1'b0);
        applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b0, 4'h0, 0, 1'b0);
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b1, 1'b0, 4'h0, 1, 1'b0);
        applyStimulus(16'h0080, 16'h0080, 1'b0, 1'b0, 1'b0, 4'h0, 0, 1'b0);
        applyStimulus(16'h1234, 16'h4321, 1'b1, 1'b1, 1'b1, 4'h9, 5, 1'b1);

        // Reset while the high pass of a wide op is in flight.
        @(negedge clock);
        req_a = 16'h7F80; req_b = 16'h0180; req_carry_in = 1'b0; req_wide = 1'b1;
        req_mode = 1'b0; req_selector = 4'h0; req_valid = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        repeat (SETTLE + 1) @(negedge clock);
        checkOutput("in high pass alu_a", 32'(alu_a), 32'h7F);
        reset = 1'b1;
        #1;
        checkOutput("mid-op reset ready", 32'(req_ready), 32'd1);
        checkAluIdle("mid-op reset");
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 3 * SETTLE; c++) begin
            @(negedge clock);
            checkOutput("no rsp after reset", 32'(rsp_valid), 32'd0);
        end
        applyStimulus(16'h0055, 16'h0022, 1'b1, 1'b0, 1'b0, 4'h0, 0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), 4'($urandom), int'($urandom_range(0, 3)),
                          1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
